// File: rtl/netlist_bist_driver.sv
// Built-in self-test driver for a combinational netlist.
// An LFSR drives the netlist inputs and a MISR compacts the netlist outputs.
// After NUM_PAT captures, the signature is compared against golden_sig.
//
// Control handshake: start is a single-cycle request. It is accepted only in
// IDLE or DONE, on the rising edge where it is high. While busy is high, start
// is ignored. done stays high until the next accepted start. pass is
// meaningful only while done is high.
module netlist_bist_driver #(
  parameter int              IN_W      = 14,
  parameter int              OUT_W     = 8,
  parameter int              NUM_PAT   = 256,
  parameter logic [IN_W-1:0] LFSR_SEED = 14'h0001,
  parameter logic [IN_W-1:0] LFSR_TAPS = 14'h3802,
  parameter logic [OUT_W-1:0] MISR_TAPS = 8'hB8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OUT_W-1:0] golden_sig,
  input  logic [OUT_W-1:0] resp_in,
  output logic [IN_W-1:0]  pat_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [IN_W-1:0] SEED_EFF =
    (LFSR_SEED == '0) ? {{(IN_W-1){1'b0}}, 1'b1} : LFSR_SEED;
  localparam logic [15:0] LAST_CNT = 16'(NUM_PAT - 1);

  state_t           state;
  state_t           state_n;
  logic [15:0]      count;
  logic [IN_W-1:0]  lfsr_n;
  logic [OUT_W-1:0] misr_n;
  logic             reload;
  logic             step;
  logic             do_cmp;

  // Next values of the pattern generator and signature register.
  always_comb begin
    lfsr_n = {pat_out[IN_W-2:0], ^(pat_out & LFSR_TAPS)};
    misr_n = {signature[OUT_W-2:0], ^(signature & MISR_TAPS)} ^ resp_in;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic and datapath control strobes.
  always_comb begin
    state_n = state;
    reload  = 1'b0;
    step    = 1'b0;
    do_cmp  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_RUN;
          reload  = 1'b1;
        end
      end
      S_RUN: begin
        // The response to the current pattern is captured on this edge.
        step = 1'b1;
        if (count == LAST_CNT) begin
          state_n = S_COMPARE;
        end
      end
      S_COMPARE: begin
        do_cmp  = 1'b1;
        state_n = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          state_n = S_RUN;
          reload  = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Pattern LFSR, signature MISR, pattern counter and pass flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_out   <= SEED_EFF;
      signature <= '0;
      count     <= '0;
      pass      <= 1'b0;
    end else if (reload) begin
      pat_out   <= SEED_EFF;
      signature <= '0;
      count     <= '0;
      pass      <= 1'b0;
    end else if (step) begin
      pat_out   <= lfsr_n;
      signature <= misr_n;
      count     <= count + 16'd1;
    end else if (do_cmp) begin
      pass      <= (signature == golden_sig);
    end
  end

  // Status flags decoded from the registered state.
  always_comb begin
    busy      = (state == S_RUN) || (state == S_COMPARE);
    done      = (state == S_DONE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_netlist_bist_driver.sv
// Self-checking bench for netlist_bist_driver: a 256-pattern instance with a
// bench-side netlist, and a 1-pattern instance for the short-run corner.
module tb_netlist_bist_driver;

  localparam int              IN_W  = 14;
  localparam int              OUT_W = 8;
  localparam logic [IN_W-1:0] SEED  = 14'h0001;
  localparam logic [IN_W-1:0] LTAPS = 14'h3802;
  localparam logic [OUT_W-1:0] MTAPS = 8'hB8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // instance A: NUM_PAT = 256
  logic             start_a = 1'b0;
  logic [OUT_W-1:0] golden_a = '0;
  logic [OUT_W-1:0] resp_a;
  logic [IN_W-1:0]  pat_a;
  logic             busy_a, done_a, pass_a;
  logic [OUT_W-1:0] sig_a;
  logic [1:0]       dbg_a;
  logic             use_net = 1'b0;

  // instance B: NUM_PAT = 1
  logic             start_b = 1'b0;
  logic [OUT_W-1:0] golden_b = '0;
  logic [OUT_W-1:0] resp_b = 8'h5A;
  logic [IN_W-1:0]  pat_b;
  logic             busy_b, done_b, pass_b;
  logic [OUT_W-1:0] sig_b;
  logic [1:0]       dbg_b;

  // Stand-in combinational netlist.
  function automatic logic [OUT_W-1:0] net_fn(input logic [IN_W-1:0] p);
    return p[7:0] ^ {p[13:8], p[1:0]} ^ (p[11:4] & p[9:2]);
  endfunction

  function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] v);
    return {v[IN_W-2:0], ^(v & LTAPS)};
  endfunction

  function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] m,
                                                 input logic [OUT_W-1:0] r);
    return {m[OUT_W-2:0], ^(m & MTAPS)} ^ r;
  endfunction

  assign resp_a = use_net ? net_fn(pat_a) : 8'h00;

  netlist_bist_driver #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_PAT(256),
    .LFSR_SEED(SEED), .LFSR_TAPS(LTAPS), .MISR_TAPS(MTAPS)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .golden_sig(golden_a),
    .resp_in(resp_a), .pat_out(pat_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .signature(sig_a), .state_dbg(dbg_a));

  netlist_bist_driver #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_PAT(1),
    .LFSR_SEED(SEED), .LFSR_TAPS(LTAPS), .MISR_TAPS(MTAPS)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .golden_sig(golden_b),
    .resp_in(resp_b), .pat_out(pat_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .signature(sig_b), .state_dbg(dbg_b));

  // scoreboard
  logic [IN_W-1:0]  exp_q[$];
  logic [OUT_W-1:0] sig_q[$];
  int n_pass  = 0;
  int n_total = 0;
  int done_rises = 0;

  always @(posedge done_a) done_rises <= done_rises + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // driver: one full run on instance A, checking patterns, busy length,
  // signature, done and pass. Returns the DUT's final signature.
  task automatic do_run(input bit mode, input bit gold_model,
                        input logic [OUT_W-1:0] gold_val, input int pulse_at,
                        input bit exp_pass, output logic [OUT_W-1:0] dut_sig);
    logic [IN_W-1:0]  m_lfsr;
    logic [OUT_W-1:0] m_misr;
    logic [OUT_W-1:0] r;
    logic [IN_W-1:0]  e;
    int busy_n;
    int t;
    use_net = mode;
    if (!gold_model) golden_a = gold_val;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    m_lfsr = SEED;
    m_misr = '0;
    busy_n = 0;
    for (int k = 0; k < 256; k++) begin
      exp_q.push_back(m_lfsr);
      if (busy_a) busy_n++;
      e = exp_q.pop_front();
      check($sformatf("pat_out[%0d]", k), 32'(pat_a), 32'(e));
      r = mode ? net_fn(m_lfsr) : 8'h00;
      m_misr = misr_step(m_misr, r);
      m_lfsr = lfsr_step(m_lfsr);
      start_a = (k == pulse_at);
      @(negedge clk);
    end
    start_a = 1'b0;
    sig_q.push_back(m_misr);
    if (gold_model) golden_a = m_misr ^ gold_val;
    t = 0;
    while (!done_a && t < 8) begin
      if (busy_a) busy_n++;
      @(negedge clk);
      t++;
    end
    check("done_high", 32'(done_a), 32'd1);
    check("busy_cycles", 32'(busy_n), 32'd257);
    check("signature", 32'(sig_a), 32'(sig_q.pop_front()));
    check("pass", 32'(pass_a), 32'(exp_pass));
    check("busy_low_done", 32'(busy_a), 32'd0);
    dut_sig = sig_a;
  endtask

  typedef struct {
    bit             mode;
    bit             gold_model;
    logic [OUT_W-1:0] gold_val;
    int             pulse_at;
    bit             exp_pass;
  } vec_t;

  vec_t vecs[5];
  logic [OUT_W-1:0] sigs[5];

  initial begin
    logic [OUT_W-1:0] s;
    int base;
    int t;

    vecs[0] = '{mode:1'b0, gold_model:1'b0, gold_val:8'h00, pulse_at:-1, exp_pass:1'b1};
    vecs[1] = '{mode:1'b0, gold_model:1'b0, gold_val:8'h01, pulse_at:-1, exp_pass:1'b0};
    vecs[2] = '{mode:1'b1, gold_model:1'b1, gold_val:8'h00, pulse_at:-1, exp_pass:1'b1};
    vecs[3] = '{mode:1'b1, gold_model:1'b1, gold_val:8'h01, pulse_at:-1, exp_pass:1'b0};
    vecs[4] = '{mode:1'b1, gold_model:1'b1, gold_val:8'h00, pulse_at:10, exp_pass:1'b1};

    // Asynchronous reset with no clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_pat_out", 32'(pat_a), 32'h0001);
    check("rst_signature", 32'(sig_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_pass", 32'(pass_a), 32'd0);
    check("rst_state", 32'(dbg_a), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      do_run(vecs[i].mode, vecs[i].gold_model, vecs[i].gold_val,
             vecs[i].pulse_at, vecs[i].exp_pass, s);
      sigs[i] = s;
      if (!vecs[i].mode) check($sformatf("zero_sig[%0d]", i), 32'(s), 32'h0);
    end
    check("sig_pulsed_vs_clean", 32'(sigs[4]), 32'(sigs[2]));

    // Abort at RUN cycle 100, then a clean rerun.
    base = done_rises;
    use_net = 1'b1;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_pat_out", 32'(pat_a), 32'h0001);
    check("abort_signature", 32'(sig_a), 32'h0);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    check("abort_pass", 32'(pass_a), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    do_run(1'b1, 1'b1, 8'h00, -1, 1'b1, s);
    check("rerun_sig", 32'(s), 32'(sigs[2]));
    check("done_rises_once", 32'(done_rises - base), 32'd1);

    // NUM_PAT = 1 corner on instance B.
    golden_b = 8'h5A;
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    check("b_run_pat", 32'(pat_b), 32'(SEED));
    check("b_run_busy", 32'(busy_b), 32'd1);
    @(negedge clk);
    check("b_cmp_sig", 32'(sig_b), 32'h5A);
    check("b_cmp_state", 32'(dbg_b), 32'd2);
    check("b_cmp_busy", 32'(busy_b), 32'd1);
    @(negedge clk);
    check("b_done", 32'(done_b), 32'd1);
    check("b_pass", 32'(pass_b), 32'd1);
    start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    check("b_restart_done", 32'(done_b), 32'd0);
    check("b_restart_pass", 32'(pass_b), 32'd0);
    check("b_restart_busy", 32'(busy_b), 32'd1);
    check("b_restart_sig", 32'(sig_b), 32'h0);
    t = 0;
    while (!done_b && t < 8) begin
      @(negedge clk);
      t++;
    end
    check("b_done2", 32'(done_b), 32'd1);
    check("b_pass2", 32'(pass_b), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
